stage_memory_access: RTL and testbench
======================================

// Module: stage_memory_access
// PURPOSE
// - MEM stage of the 5-stage RV32 core; sits between the execute stage and write-back.
// - Holds the byte-addressed data memory: stores on the clock edge, reads combinationally.
// - Resolves branches and jumps into pc_sel.
// - Forwards the ALU result, the rd address and the jump/branch target to the next stage.
// PARAMETERS
// - MEM_BYTES  1024  data memory size in bytes (power of 2); address = alu_result_in mod MEM_BYTES
// PORTS
// - clk                   in   1   rising-edge clock
// - reset_n               in   1   asynchronous, active-HIGH reset (1 = in reset) despite the name
// - alu_result_in         in   32  memory byte address / ALU result from execute
// - data_mem_wr_data      in   32  store data (rs2)
// - data_mem_wr_en        in   DataMemWrControl  store size selector
// - zero                  in   1   ALU zero flag (rs1 == rs2)
// - jump_branch_signal    in   JumpBranchControl  branch/jump kind
// - jump_branch_addr_in   in   32  target address from execute
// - reg_file_wr_addr_in   in   32  destination register index (zero-extended)
// - data_mem_rd_data      out  32  load data
// - alu_result_out        out  32  = alu_result_in
// - jump_branch_addr_out  out  32  = jump_branch_addr_in
// - reg_file_wr_addr_out  out  32  = reg_file_wr_addr_in
// - pc_sel                out  1   1 = fetch takes jump_branch_addr_out
// BEHAVIOUR
// - Memory: byte array mem[MEM_BYTES], little-endian; a = alu_result_in mod MEM_BYTES.
// - Address indices wrap modulo MEM_BYTES; unaligned accesses are legal, no traps.
// - Read (combinational): rd_data = {mem[a+3],mem[a+2],mem[a+1],mem[a]}.
//   - Always driven, independent of wr_en.
//   - Read-during-write returns the old data until the edge.
// - Write (posedge clk, only when reset_n==0):
//   - DATA_MEM_W_WR: bytes a..a+3 <= wr_data[31:0].
//   - DATA_MEM_H_WR: bytes a..a+1 <= wr_data[15:0].
//   - DATA_MEM_B_WR: byte a <= wr_data[7:0].
//   - DATA_MEM_NO_WR: no change.
// - Reset: asserting reset_n clears every memory byte to 0 asynchronously.
//   - Writes are blocked while reset_n==1.
//   - Write is ignored on the releasing edge if reset is still high at that edge.
// - pc_sel (combinational), forced 0 while reset_n==1:
//   - JUMP_BRANCH_NO: 0.
//   - BRANCH_EQ: zero.
//   - BRANCH_NE: ~zero.
//   - JUMP_AL, JUMP_ALR: 1.
// - Pass-throughs are combinational, zero latency, not modified by reset.
// - No handshake; one access per cycle; no state other than memory.
// STRUCTURE
// - package_project_typedefs holds the shared encodings:
//   - JumpBranchControl: JUMP_BRANCH_NO, BRANCH_EQ, BRANCH_NE, JUMP_AL, JUMP_ALR.
//   - DataMemWrControl: DATA_MEM_NO_WR, DATA_MEM_W_WR, DATA_MEM_H_WR, DATA_MEM_B_WR.
// - Sub-module data_memory (clk, reset_n, addr, wr_data, wr_en, rd_data) holds the array.
// - Branch resolution and pass-throughs stay in the top.
// TESTING
// - Reset: reset_n=1, any inputs -> pc_sel=0; rd_data at addr 0 = 0.
//   - After release, every byte reads 0.
// - Word store: alu_result_in=0, wr_data=500, DATA_MEM_W_WR, one edge -> rd_data@0 = 500.
//   - BRANCH_EQ with zero=0 -> pc_sel=0.
// - Unaligned store: then alu_result_in=1, wr_data=550, W_WR, one edge:
//   - rd_data@1 = 550.
//   - rd_data@0 = 32'h000226F4 (141044).
//   - BRANCH_NE, zero=0 -> pc_sel=1.
// - Jumps/branch table: JUMP_ALR and JUMP_AL -> pc_sel=1 for zero=0 and zero=1.
//   - BRANCH_EQ zero=1 -> 1; BRANCH_NE zero=1 -> 0.
//   - jump_branch_addr_out tracks the input (e.g. 32'h0000_0040).
// - Sizes/wrap: H_WR 32'hAABBCCDD @8 -> rd@8 = 32'h0000CCDD.
//   - B_WR 32'h11 @MEM_BYTES-1: write wraps -> rd@(MEM_BYTES-1) byte0 = 8'h11.
// - Mid-operation reset: after stores, assert reset_n for half a cycle -> all bytes 0 immediately.
//   - A W_WR presented while reset_n=1 leaves memory at 0.

Source files
------------

// File: rtl/stage_memory_access_pkg.sv
// Shared control encodings for the RV32 pipeline stages.
//   JumpBranchControl : branch/jump kind from execute.
//   DataMemWrControl  : store size selector for the data memory.
package package_project_typedefs;

   typedef enum logic [2:0] {
      JUMP_BRANCH_NO = 3'd0,
      BRANCH_EQ      = 3'd1,
      BRANCH_NE      = 3'd2,
      JUMP_AL        = 3'd3,
      JUMP_ALR       = 3'd4
   } JumpBranchControl;

   typedef enum logic [1:0] {
      DATA_MEM_NO_WR = 2'd0,
      DATA_MEM_W_WR  = 2'd1,
      DATA_MEM_H_WR  = 2'd2,
      DATA_MEM_B_WR  = 2'd3
   } DataMemWrControl;

   localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/stage_memory_access_if.sv
// Execute -> MEM -> write-back bus of the MEM stage.
//   slave  : seen by the MEM stage (takes *_in / control, drives results).
//   master : seen by the upstream/downstream driver (e.g. a bench).
interface stage_memory_access_if;
   import package_project_typedefs::*;

   logic [31:0]      alu_result_in;
   logic [31:0]      data_mem_wr_data;
   DataMemWrControl  data_mem_wr_en;
   logic             zero;
   JumpBranchControl jump_branch_signal;
   logic [31:0]      jump_branch_addr_in;
   logic [31:0]      reg_file_wr_addr_in;

   logic [31:0]      data_mem_rd_data;
   logic [31:0]      alu_result_out;
   logic [31:0]      jump_branch_addr_out;
   logic [31:0]      reg_file_wr_addr_out;
   logic             pc_sel;

   modport slave (
      input  alu_result_in, data_mem_wr_data, data_mem_wr_en, zero,
             jump_branch_signal, jump_branch_addr_in, reg_file_wr_addr_in,
      output data_mem_rd_data, alu_result_out, jump_branch_addr_out,
             reg_file_wr_addr_out, pc_sel
   );

   modport master (
      output alu_result_in, data_mem_wr_data, data_mem_wr_en, zero,
             jump_branch_signal, jump_branch_addr_in, reg_file_wr_addr_in,
      input  data_mem_rd_data, alu_result_out, jump_branch_addr_out,
             reg_file_wr_addr_out, pc_sel
   );

endinterface

// File: rtl/stage_memory_access_data_memory.sv
// Byte-addressed little-endian data memory.
//   clk, reset_n : clock; reset_n is active-HIGH async reset that clears all bytes.
//   addr         : byte address (already reduced mod MEM_BYTES).
//   wr_data      : store data; wr_en selects word/half/byte/none.
//   rd_data      : combinational 4-byte read starting at addr (wraps).
module data_memory
   import package_project_typedefs::*;
#(
   parameter int unsigned MEM_BYTES = 1024,
   localparam int unsigned AW       = $clog2(MEM_BYTES)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [AW-1:0]   addr,
   input  logic [31:0]     wr_data,
   input  DataMemWrControl wr_en,
   output logic [31:0]     rd_data
);

   logic [7:0] mem [MEM_BYTES];

   // Byte lane addresses; AW-bit arithmetic gives the wrap at the top of memory.
   logic [WORD_BYTES-1:0][AW-1:0] lane_addr;

   for (genvar g = 0; g < WORD_BYTES; g++) begin : g_lane
      assign lane_addr[g] = addr + AW'(g);
      assign rd_data[8*g +: 8] = mem[lane_addr[g]];
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
      end else begin
         unique case (wr_en)
            DATA_MEM_W_WR: for (int i = 0; i < 4; i++) mem[lane_addr[i]] <= wr_data[8*i +: 8];
            DATA_MEM_H_WR: for (int i = 0; i < 2; i++) mem[lane_addr[i]] <= wr_data[8*i +: 8];
            DATA_MEM_B_WR: mem[lane_addr[0]] <= wr_data[7:0];
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/stage_memory_access.sv
// MEM stage of the 5-stage RV32 core.
//   clk, reset_n : clock; reset_n is an active-HIGH async reset.
//   bus (slave)  : execute-side inputs, load data, pass-throughs and pc_sel.
// Holds the data memory, resolves branches/jumps into pc_sel and forwards
// ALU result, rd index and jump target with zero latency.
module stage_memory_access
   import package_project_typedefs::*;
#(
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic                   clk,
   input  logic                   reset_n,
   stage_memory_access_if.slave   bus
);

   localparam int unsigned AW = $clog2(MEM_BYTES);

   logic pc_sel_c;

   data_memory #(.MEM_BYTES(MEM_BYTES)) u_data_memory (
      .clk     (clk),
      .reset_n (reset_n),
      .addr    (bus.alu_result_in[AW-1:0]),
      .wr_data (bus.data_mem_wr_data),
      .wr_en   (bus.data_mem_wr_en),
      .rd_data (bus.data_mem_rd_data)
   );

   // Reset holds fetch on the sequential path regardless of what execute presents.
   always_comb begin
      pc_sel_c = 1'b0;
      if (!reset_n) begin
         unique case (bus.jump_branch_signal)
            BRANCH_EQ:          pc_sel_c = bus.zero;
            BRANCH_NE:          pc_sel_c = ~bus.zero;
            JUMP_AL, JUMP_ALR:  pc_sel_c = 1'b1;
            default:            pc_sel_c = 1'b0;
         endcase
      end
   end

   assign bus.pc_sel               = pc_sel_c;
   assign bus.alu_result_out       = bus.alu_result_in;
   assign bus.jump_branch_addr_out = bus.jump_branch_addr_in;
   assign bus.reg_file_wr_addr_out = bus.reg_file_wr_addr_in;

endmodule

// File: tb/tb_stage_memory_access.sv
// Directed bench for stage_memory_access: reset, word/half/byte stores,
// unaligned and wrapping accesses, branch/jump resolution, mid-run reset.
module tb_stage_memory_access;
   import package_project_typedefs::*;

   localparam int unsigned MEM_BYTES = 1024;

   logic clk = 1'b0;
   logic reset_n;
   int   n_vec = 0;
   int   n_err = 0;

   stage_memory_access_if bus ();

   stage_memory_access #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Store on one rising edge, then drop the write enable.
   task automatic store(input logic [31:0] a, input logic [31:0] d, input DataMemWrControl k);
      @(negedge clk);
      bus.alu_result_in    = a;
      bus.data_mem_wr_data = d;
      bus.data_mem_wr_en   = k;
      @(posedge clk);
      #1;
      bus.data_mem_wr_en   = DATA_MEM_NO_WR;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus.alu_result_in = a;
      #1;
      d = bus.data_mem_rd_data;
   endtask

   task automatic br(input JumpBranchControl k, input logic z);
      bus.jump_branch_signal = k;
      bus.zero               = z;
      #1;
   endtask

   task automatic scan_zero(input string tag);
      logic [31:0] acc, d;
      acc = '0;
      for (int a = 0; a < MEM_BYTES; a += 4) begin
         rd(a, d);
         acc |= d;
      end
      chk(tag, acc, 32'h0);
   endtask

   logic [31:0] d;

   initial begin
      reset_n                 = 1'b1;
      bus.alu_result_in       = 32'h0;
      bus.data_mem_wr_data    = 32'hDEAD_BEEF;
      bus.data_mem_wr_en      = DATA_MEM_W_WR;
      bus.zero                = 1'b1;
      bus.jump_branch_signal  = JUMP_AL;
      bus.jump_branch_addr_in = 32'h0000_0040;
      bus.reg_file_wr_addr_in = 32'd5;

      // Reset: writes blocked, pc_sel forced low, pass-throughs live.
      @(posedge clk); #1;
      chk("rst_pc_sel", {31'b0, bus.pc_sel}, 32'h0);
      rd(0, d);
      chk("rst_rd0", d, 32'h0);
      chk("rst_jb_addr", bus.jump_branch_addr_out, 32'h0000_0040);
      chk("rst_rd_idx", bus.reg_file_wr_addr_out, 32'd5);
      bus.data_mem_wr_en = DATA_MEM_NO_WR;
      @(negedge clk);
      reset_n = 1'b0;
      scan_zero("post_rst_all_zero");

      // Word store, plus read-during-write returning the old data.
      @(negedge clk);
      bus.alu_result_in    = 32'd0;
      bus.data_mem_wr_data = 32'd500;
      bus.data_mem_wr_en   = DATA_MEM_W_WR;
      #1;
      chk("rdw_old", bus.data_mem_rd_data, 32'h0);
      @(posedge clk); #1;
      bus.data_mem_wr_en = DATA_MEM_NO_WR;
      rd(0, d);
      chk("w_store_rd0", d, 32'd500);
      chk("alu_pass", bus.alu_result_out, 32'd0);
      br(BRANCH_EQ, 1'b0);
      chk("beq_z0", {31'b0, bus.pc_sel}, 32'h0);

      // Unaligned word store overlapping the first.
      store(32'd1, 32'd550, DATA_MEM_W_WR);
      rd(1, d);
      chk("unal_rd1", d, 32'd550);
      rd(0, d);
      chk("unal_rd0", d, 32'h0002_26F4);
      br(BRANCH_NE, 1'b0);
      chk("bne_z0", {31'b0, bus.pc_sel}, 32'h1);

      // Branch/jump table.
      br(JUMP_ALR, 1'b0);       chk("jalr_z0", {31'b0, bus.pc_sel}, 32'h1);
      br(JUMP_ALR, 1'b1);       chk("jalr_z1", {31'b0, bus.pc_sel}, 32'h1);
      br(JUMP_AL, 1'b0);        chk("jal_z0",  {31'b0, bus.pc_sel}, 32'h1);
      br(JUMP_AL, 1'b1);        chk("jal_z1",  {31'b0, bus.pc_sel}, 32'h1);
      br(BRANCH_EQ, 1'b1);      chk("beq_z1",  {31'b0, bus.pc_sel}, 32'h1);
      br(BRANCH_NE, 1'b1);      chk("bne_z1",  {31'b0, bus.pc_sel}, 32'h0);
      br(JUMP_BRANCH_NO, 1'b1); chk("no_jb",   {31'b0, bus.pc_sel}, 32'h0);
      bus.jump_branch_addr_in = 32'h0000_1234;
      bus.reg_file_wr_addr_in = 32'd31;
      bus.alu_result_in       = 32'hFFFF_FFFC;
      #1;
      chk("jb_addr_pass", bus.jump_branch_addr_out, 32'h0000_1234);
      chk("rd_idx_pass", bus.reg_file_wr_addr_out, 32'd31);
      chk("alu_pass_hi", bus.alu_result_out, 32'hFFFF_FFFC);

      // Sizes and wrap.
      store(32'd8, 32'hAABB_CCDD, DATA_MEM_H_WR);
      rd(8, d);
      chk("h_store", d, 32'h0000_CCDD);
      store(MEM_BYTES - 1, 32'h0000_0011, DATA_MEM_B_WR);
      rd(MEM_BYTES - 1, d);
      chk("b_wrap_byte0", {24'b0, d[7:0]}, 32'h11);
      chk("b_wrap_word", d, 32'h0226_F411);
      store(MEM_BYTES - 2, 32'hCAFE_BABE, DATA_MEM_W_WR);
      rd(0, d);
      chk("w_wrap_rd0", d, 32'h0002_CAFE);
      rd(32'h0000_0408, d);     // alias of byte 8 above MEM_BYTES
      chk("addr_alias", d, 32'h0000_CCDD);

      // Mid-operation reset: immediate clear, store during reset ignored.
      @(negedge clk);
      bus.alu_result_in  = 32'd8;
      reset_n            = 1'b1;
      #1;
      chk("mid_rst_rd8", bus.data_mem_rd_data, 32'h0);
      bus.jump_branch_signal = JUMP_AL;
      #1;
      chk("mid_rst_pc_sel", {31'b0, bus.pc_sel}, 32'h0);
      bus.alu_result_in    = 32'd0;
      bus.data_mem_wr_data = 32'h1234_5678;
      bus.data_mem_wr_en   = DATA_MEM_W_WR;
      @(posedge clk); #1;
      bus.data_mem_wr_en = DATA_MEM_NO_WR;
      @(negedge clk);
      reset_n = 1'b0;
      rd(0, d);
      chk("wr_in_rst_blocked", d, 32'h0);
      scan_zero("mid_rst_all_zero");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
